posit_to_int_pipe: RTL and testbench

Pipelined decoder from a 16-bit posit (es = 0) to an 8-bit unsigned integer. It is the inverse of the integer-to-posit path and returns posit results from the vision datapath to integer pixel and coefficient space. The block has three register stages, a valid/ready handshake on both sides, full throughput, and flags for NaR, negative and saturated results.

---
 rtl/posit_to_int_pipe.sv | 168 ++++++++++++++++
 tb/tb_posit_to_int_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/posit_to_int_pipe.sv
// Three-stage posit(16, es=0) to unsigned 8-bit integer decoder.
// Stage 1 classifies specials, stage 2 decodes the regime, stage 3 scales and rounds.
module posit_to_int_pipe #(
    parameter int N  = 8,
    parameter int P  = 16,
    parameter int es = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [P-1:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         out_nar,
    output logic         out_neg,
    output logic         out_sat
);

    localparam int STAGES = 3;
    localparam int BW     = P - 1;          // body width
    localparam int FW     = BW - 1;         // widest possible fraction field
    localparam int RW     = $clog2(P);      // regime run length / fraction length
    localparam int KW     = RW + 1;         // signed scale exponent
    localparam int FB     = BW;             // fractional bits kept while scaling
    localparam int MW     = FB + BW + N;    // scaling workspace
    localparam int IW     = MW - FB;        // integer part width

    localparam logic signed [KW-1:0] K_SAT = KW'(N);
    localparam logic signed [KW-1:0] K_LOW = KW'(-2);

    generate
        if (es != 0) begin : g_es_check
            $error("posit_to_int_pipe supports es = 0 only");
        end
    endgenerate

    typedef struct packed {
        logic          nar;
        logic          neg;
        logic          zero;
        logic [BW-1:0] body;
    } s1_t;

    typedef struct packed {
        logic                 nar;
        logic                 neg;
        logic                 zero;
        logic signed [KW-1:0] k;
        logic [RW-1:0]        fl;
        logic [FW-1:0]        frac;
    } s2_t;

    typedef struct packed {
        logic [N-1:0] val;
        logic         nar;
        logic         neg;
        logic         sat;
    } res_t;

    logic [STAGES:1] vld_pipe;
    logic            advance;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    res_t            res_d, res_q;

    // Whole pipeline moves as one: any stall at the output freezes every stage.
    assign advance   = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];
    assign out       = res_q.val;
    assign out_nar   = res_q.nar;
    assign out_neg   = res_q.neg;
    assign out_sat   = res_q.sat;

    always_comb begin
        s1_d      = '0;
        s1_d.nar  = (in == {1'b1, {(P-1){1'b0}}});
        s1_d.neg  = in[P-1] && !s1_d.nar;
        s1_d.zero = (in == '0);
        s1_d.body = in[BW-1:0];
    end

    logic [RW-1:0] run;
    logic          done;
    logic [KW-1:0] kp;

    always_comb begin
        run  = '0;
        done = 1'b0;
        for (int i = BW-1; i >= 0; i--) begin
            if (!done) begin
                if (s1_q.body[i] == s1_q.body[BW-1]) run = run + RW'(1);
                else                                 done = 1'b1;
            end
        end
    end

    always_comb begin
        s2_d      = '0;
        s2_d.nar  = s1_q.nar;
        s2_d.neg  = s1_q.neg;
        s2_d.zero = s1_q.zero;
        kp        = {1'b0, run};
        s2_d.k    = s1_q.body[BW-1] ? $signed(kp - KW'(1)) : $signed(-kp);
        // An all-ones or all-zeros body has no terminator, so no fraction bits remain.
        s2_d.fl   = (run >= RW'(BW-1)) ? '0 : RW'(BW-1) - run;
        s2_d.frac = s1_q.body[FW-1:0] & ~({FW{1'b1}} << s2_d.fl);
    end

    logic signed [KW-1:0] k;
    logic signed [KW:0]   diff;
    logic [KW:0]          sh;
    logic [BW-1:0]        mant;
    logic [MW-1:0]        ext0, ext;
    logic [IW-1:0]        ipart;
    logic                 guard, sticky;
    logic [IW:0]          rounded;

    always_comb begin
        k       = s2_q.k;
        mant    = {1'b0, s2_q.frac} | (BW'(1) << s2_q.fl);
        diff    = $signed({k[KW-1], k}) - $signed({2'b00, s2_q.fl});
        sh      = (diff > 0) ? diff : -diff;
        // Mantissa sits above FB zero bits so a right shift never drops the sticky bits.
        ext0    = {{(MW-FB-BW){1'b0}}, mant, {FB{1'b0}}};
        ext     = (diff > 0) ? (ext0 << sh) : (ext0 >> sh);
        ipart   = ext[MW-1:FB];
        guard   = ext[FB-1];
        sticky  = |ext[FB-2:0];
        rounded = {1'b0, ipart} + {{IW{1'b0}}, guard & (sticky | ipart[0])};

        res_d = '0;
        if (s2_q.nar) begin
            res_d.nar = 1'b1;
        end else if (s2_q.neg) begin
            res_d.neg = 1'b1;
        end else if (s2_q.zero) begin
            res_d.val = '0;
        end else if (k >= K_SAT) begin
            res_d.val = '1;
            res_d.sat = 1'b1;
        end else if (k <= K_LOW) begin
            res_d.val = '0;
        end else if (rounded > {{(IW-N+1){1'b0}}, {N{1'b1}}}) begin
            res_d.val = '1;
            res_d.sat = 1'b1;
        end else begin
            res_d.val = rounded[N-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            res_q    <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_posit_to_int_pipe.sv
// Bench for posit_to_int_pipe: directed vectors plus random traffic against an
// arithmetic reference model, with a result scoreboard and handshake checks.
module tb_posit_to_int_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in;
    logic [7:0]  out;
    logic        out_nar, out_neg, out_sat;

    always #5 clk = ~clk;

    posit_to_int_pipe #(.N(8), .P(16), .es(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_nar(out_nar), .out_neg(out_neg), .out_sat(out_sat)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [10:0] exp_q[$];     // {nar, neg, sat, out}
    int          acc_q[$];
    logic [10:0] dir_exp[$];   // hand-computed expectations for directed operands
    bit          vhist[0:4095];
    bit          chk_lat = 0;
    bit          chk_bub = 0;
    bit          held    = 0;
    logic [10:0] held_val;

    // Value = 2^k * (1 + f/2^fl); scaled by 2^16 so rounding is plain integer work.
    function automatic logic [10:0] ref_conv(input logic [15:0] p);
        int     r, k, fl, f, q;
        longint sc, rem;
        bit     first;
        if (p == 16'h0000) return 11'h000;
        if (p == 16'h8000) return 11'h400;
        if (p[15])         return 11'h200;
        first = p[14];
        r = 0;
        for (int i = 14; i >= 0; i--) begin
            if (p[i] != first) break;
            r++;
        end
        k  = first ? r - 1 : -r;
        fl = (r >= 14) ? 0 : 14 - r;
        f  = int'(p[13:0]) & ((1 << fl) - 1);
        if (k >= 8)  return 11'h1FF;
        if (k <= -2) return 11'h000;
        sc  = longint'((1 << fl) + f) << (k - fl + 16);
        q   = int'(sc >> 16);
        rem = sc & 64'hFFFF;
        if (rem > 32768 || (rem == 32768 && (q % 2) == 1)) q++;
        if (q > 255) return 11'h1FF;
        return {3'b000, 8'(q)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit rdy, output bit acc);
        logic [10:0] e, cur;
        int          ac;
        in_valid  = v;
        in        = d;
        out_ready = rdy;
        #1;
        cur = {out_nar, out_neg, out_sat, out};
        check("in_ready", in_ready, !out_valid || rdy);
        if (held) check("stall_hold", {out_valid, cur}, {1'b1, held_val});
        if (out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_valid, 0);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                check("result", cur, e);
                if (chk_lat) check("latency", cyc - ac, 3);
            end
        end
        if (chk_bub && cyc >= 3) check("bubble", out_valid, vhist[cyc-3]);
        held     = out_valid && !rdy;
        held_val = cur;
        acc      = v && in_ready;
        if (cyc < 4096) vhist[cyc] = acc;
        if (acc) begin
            if (dir_exp.size() > 0) exp_q.push_back(dir_exp.pop_front());
            else                    exp_q.push_back(ref_conv(d));
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 16'h0, 1'b1, a);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit          a;
        bit          rdy;
        int          idx;
        logic [15:0] op;
        logic [15:0] exact[4] = '{16'h4000, 16'h6800, 16'h7FA4, 16'h0000};
        logic [10:0] exact_e[4] = '{11'h001, 11'h003, 11'h0C8, 11'h000};
        logic [15:0] spec[8] = '{16'h2000, 16'h3000, 16'h6000, 16'h6400,
                                 16'h1000, 16'h7FFF, 16'h8000, 16'hC000};
        logic [10:0] spec_e[8] = '{11'h000, 11'h001, 11'h002, 11'h002,
                                   11'h000, 11'h1FF, 11'h400, 11'h200};
        logic [15:0] bp_ops[5] = '{16'h4800, 16'h5A00, 16'h7C80, 16'h6C00, 16'h3800};

        rst = 1'b1; in_valid = 1'b0; in = 16'h0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_flags", {out_nar, out_neg, out_sat}, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Exact values back to back with 3-cycle latency
        chk_lat = 1;
        for (int i = 0; i < 4; i++) dir_exp.push_back(exact_e[i]);
        for (int i = 0; i < 4; i++) step(1'b1, exact[i], 1'b1, a);
        drain();

        // Rounding and special operands
        for (int i = 0; i < 8; i++) dir_exp.push_back(spec_e[i]);
        for (int i = 0; i < 8; i++) step(1'b1, spec[i], 1'b1, a);
        drain();

        // Backpressure: out_ready low for 4 cycles mid-stream
        chk_lat = 0;
        idx = 0;
        for (int c = 0; c < 30 && idx < 5; c++) begin
            rdy = !(c >= 3 && c < 7);
            step(1'b1, bp_ops[idx], rdy, a);
            if (a) idx++;
        end
        check("bp_accepted", idx, 5);
        drain();

        // Bubbles: out_valid mirrors the accept pattern 3 cycles later
        chk_bub = 1;
        chk_lat = 1;
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 16'h4000 + 16'(i * 16'h0400), 1'b1, a);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, a);
        chk_bub = 0;
        drain();

        // Random traffic against the reference model
        chk_lat = 0;
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 5))
                0:       op = 16'($urandom);
                1:       op = 16'h8000;
                2, 3:    op = 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
                4:       op = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
                default: op = {1'b0, 15'($urandom)};
            endcase
            step($urandom_range(0, 3) != 0, op, $urandom_range(0, 4) != 0, a);
        end
        drain();

        // Reset flush with 3 operands in flight
        chk_lat = 1;
        step(1'b1, 16'h6800, 1'b1, a);
        step(1'b1, 16'h7FA4, 1'b1, a);
        step(1'b1, 16'h5000, 1'b1, a);
        #2 rst = 1'b1;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        exp_q.delete();
        acc_q.delete();
        held = 0;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1, a);
        dir_exp.push_back(11'h001);
        step(1'b1, 16'h4000, 1'b1, a);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
